// File: rtl/audio_pkg.sv
// Shared audio constants and helpers: volume encodings and signed saturation.
package audio_pkg;

  localparam logic [1:0] VOL_MUTE  = 2'd0;
  localparam logic [1:0] VOL_M12   = 2'd1;
  localparam logic [1:0] VOL_M6    = 2'd2;
  localparam logic [1:0] VOL_UNITY = 2'd3;

  // Clamp a signed value into the range of an out_w-bit two's-complement word.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] x, input int out_w);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (out_w - 1));
    if (x > max_v) return max_v;
    else if (x < min_v) return min_v;
    else return x;
  endfunction

endpackage

// File: rtl/audio_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH=1 collapses to a single holding register.
module audio_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  logic do_push;
  logic do_pop;

  // A push into a full FIFO is still taken when a pop frees a slot on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  if (DEPTH == 1) begin : g_hold
    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;

    always_ff @(posedge clk) begin
      if (do_push) data_reg <= wdata;
    end

    always_ff @(posedge clk) begin
      if (reset) valid_reg <= 1'b0;
      else if (do_push) valid_reg <= 1'b1;
      else if (do_pop) valid_reg <= 1'b0;
    end

    assign rdata = data_reg;
    assign empty = !valid_reg;
    assign full  = valid_reg;
  end else begin : g_ring
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;

    always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= wdata;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (do_push && !do_pop) count_reg <= count_reg + 1'b1;
        else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
      end
    end

    assign rdata = mem[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign full  = (count_reg == FULL_CNT);
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S transmitter: sample-pair buffer, shift/saturate/volume per channel, optional mono mix.
// Define I2S_AUDIO_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module i2s_audio_tx
  import audio_pkg::*;
#(
  parameter int IN_W        = 18,
  parameter int OUT_W       = 16,
  parameter int SLOT_W      = 16,
  parameter int AUDIO_SHIFT = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      bck_div,
  input  logic            stereo,
  input  logic [1:0]      volume,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_l,
  input  logic [IN_W-1:0] in_r,
  output logic            i2s_bck,
  output logic            i2s_ws,
  output logic            i2s_din,
  output logic            underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BW = $clog2(FRAME_W);
  localparam logic [BW-1:0] B_LAST  = BW'(FRAME_W - 1);
  localparam logic [BW-1:0] B_RIGHT = BW'(SLOT_W);
`ifdef I2S_AUDIO_TX_FIFO_EN
  localparam int BUF_DEPTH = FIFO_DEPTH;
`else
  localparam int BUF_DEPTH = 1;
`endif

  if (OUT_W >= IN_W || SLOT_W < OUT_W || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("i2s_audio_tx: illegal parameter combination");
  end

  logic [7:0]         div_reg;
  logic [7:0]         cnt_reg;
  logic               bck_reg;
  logic               ws_reg;
  logic               din_reg;
  logic               underrun_reg;
  logic               ready_en_reg;
  logic [BW-1:0]      b_reg;
  logic [FRAME_W-1:0] sh_reg;

  logic [7:0]          div_eff;
  logic                tick;
  logic                fall;
  logic                frame_start;
  logic [BW-1:0]       b_next;
  logic                push;
  logic                fifo_empty;
  logic                fifo_full;
  logic [2*IN_W-1:0]   head;
  logic signed [OUT_W-1:0] l_proc;
  logic signed [OUT_W-1:0] r_proc;
  logic signed [OUT_W-1:0] l_out;
  logic signed [OUT_W-1:0] r_out;
  logic signed [OUT_W:0]   mono_sum;
  logic [FRAME_W-1:0]  frame_data;

  function automatic logic signed [OUT_W-1:0] process_sample(input logic signed [IN_W-1:0] x,
                                                             input logic [1:0] vol);
    logic signed [IN_W-1:0]  shifted;
    logic signed [31:0]      wide;
    logic signed [OUT_W-1:0] sat;
    shifted = x >>> AUDIO_SHIFT;
    wide = 32'(shifted);
    sat = OUT_W'(saturate(wide, OUT_W));
    case (vol)
      VOL_MUTE: return '0;
      VOL_M12:  return sat >>> 2;
      VOL_M6:   return sat >>> 1;
      default:  return sat;
    endcase
  endfunction

  function automatic logic [SLOT_W-1:0] to_slot(input logic [OUT_W-1:0] s);
    logic [SLOT_W+OUT_W-1:0] tmp;
    tmp = {s, {SLOT_W{1'b0}}};
    return tmp[SLOT_W+OUT_W-1 -: SLOT_W];
  endfunction

  assign div_eff     = (div_reg == 8'd0) ? 8'd1 : div_reg;
  assign tick        = (cnt_reg == div_eff);
  assign fall        = tick && bck_reg;
  assign frame_start = fall && (b_reg == B_LAST);
  assign b_next      = frame_start ? '0 : b_reg + 1'b1;

  // The frame-start pop frees a slot, so a full buffer can still take a pair on that edge.
  assign in_ready = ready_en_reg && (!fifo_full || frame_start);
  assign push     = in_valid && in_ready;

  audio_fifo #(
    .WIDTH(2 * IN_W),
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .wdata({in_l, in_r}),
    .pop  (frame_start),
    .rdata(head),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  always_comb begin
    l_proc   = process_sample(head[2*IN_W-1:IN_W], volume);
    r_proc   = process_sample(head[IN_W-1:0], volume);
    // Sum on OUT_W+1 bits; dropping the LSB is the halving and cannot overflow.
    mono_sum = $signed({l_proc[OUT_W-1], l_proc}) + $signed({r_proc[OUT_W-1], r_proc});
    l_out    = l_proc;
    r_out    = r_proc;
    if (!stereo) begin
      l_out = mono_sum[OUT_W:1];
      r_out = mono_sum[OUT_W:1];
    end
    frame_data = fifo_empty ? '0 : {to_slot(l_out), to_slot(r_out)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg      <= bck_div;
      cnt_reg      <= 8'd0;
      bck_reg      <= 1'b0;
      b_reg        <= B_LAST;
      ws_reg       <= 1'b0;
      din_reg      <= 1'b0;
      sh_reg       <= '0;
      underrun_reg <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      underrun_reg <= frame_start && fifo_empty;
      if (tick) begin
        cnt_reg <= 8'd0;
        bck_reg <= ~bck_reg;
      end else begin
        cnt_reg <= cnt_reg + 8'd1;
      end
      // Data leaves the shifter one BCK late, so the old frame's last bit lands at b=0.
      if (fall) begin
        b_reg   <= b_next;
        ws_reg  <= (b_next >= B_RIGHT);
        din_reg <= sh_reg[FRAME_W-1];
        sh_reg  <= frame_start ? frame_data : {sh_reg[FRAME_W-2:0], 1'b0};
      end
      if (frame_start) div_reg <= bck_div;
    end
  end

  assign i2s_bck  = bck_reg;
  assign i2s_ws   = ws_reg;
  assign i2s_din  = din_reg;
  assign underrun = underrun_reg;

endmodule
